// File: rtl/mult_div_unit.sv
// Iterative signed 32x32 multiplier / 32/32 divider, one radix-2 step per clock.
// Results land in HI/LO on a single FINISH edge and are announced by a one-cycle done pulse.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             multOp,
  input  logic             divOp,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             divZero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MULT   = 2'd1,
    DIV    = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               sign_q, sign_d;
  logic               dsign_q, dsign_d;
  logic               dz_q, dz_d;
  logic               is_mult_q, is_mult_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               divzero_q, divzero_d;

  logic [WIDTH:0]     sum_s;
  logic [2*WIDTH-1:0] shifted_s;
  logic [2*WIDTH-1:0] prod_s;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    mag = v[WIDTH-1] ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

  // Next-state, datapath step and output register inputs
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    a_d       = a_q;
    b_d       = b_q;
    sign_d    = sign_q;
    dsign_d   = dsign_q;
    dz_d      = dz_q;
    is_mult_d = is_mult_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    divzero_d = 1'b0;
    sum_s     = {(WIDTH+1){1'b0}};
    shifted_s = {(2*WIDTH){1'b0}};
    prod_s    = {(2*WIDTH){1'b0}};

    case (state_q)
      IDLE: begin
        if (multOp || divOp) begin
          a_d       = mag(srcA);
          b_d       = mag(srcB);
          sign_d    = srcA[WIDTH-1] ^ srcB[WIDTH-1];
          dsign_d   = srcA[WIDTH-1];
          cnt_d     = CW'(WIDTH-1);
          busy_d    = 1'b1;
          is_mult_d = multOp;
          if (multOp) begin
            dz_d    = 1'b0;
            acc_d   = {{WIDTH{1'b0}}, mag(srcB)};
            state_d = MULT;
          end else begin
            dz_d    = (srcB == {WIDTH{1'b0}});
            acc_d   = {{WIDTH{1'b0}}, mag(srcA)};
            state_d = (srcB == {WIDTH{1'b0}}) ? FINISH : DIV;
          end
        end else begin
          busy_d = 1'b0;
        end
      end
      MULT: begin
        // Upper half gains the multiplicand when the current multiplier bit is set; carry shifts in.
        sum_s = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
        acc_d = {sum_s, acc_q[WIDTH-1:1]};
        if (cnt_q == {CW{1'b0}}) begin
          state_d = FINISH;
        end else begin
          cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
        end
      end
      DIV: begin
        // acc holds {remainder, quotient}; the dividend bits drain out of the low half.
        shifted_s = {acc_q[2*WIDTH-2:0], 1'b0};
        if (shifted_s[2*WIDTH-1:WIDTH] >= b_q) begin
          acc_d = {shifted_s[2*WIDTH-1:WIDTH] - b_q, shifted_s[WIDTH-1:1], 1'b1};
        end else begin
          acc_d = shifted_s;
        end
        if (cnt_q == {CW{1'b0}}) begin
          state_d = FINISH;
        end else begin
          cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
        end
      end
      FINISH: begin
        prod_s = sign_q ? (~acc_q + {{(2*WIDTH-1){1'b0}}, 1'b1}) : acc_q;
        if (dz_q) begin
          divzero_d = 1'b1;
        end else if (is_mult_q) begin
          hi_d = prod_s[2*WIDTH-1:WIDTH];
          lo_d = prod_s[WIDTH-1:0];
        end else begin
          lo_d = sign_q  ? (~acc_q[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, 1'b1}) : acc_q[WIDTH-1:0];
          hi_d = dsign_q ? (~acc_q[2*WIDTH-1:WIDTH] + {{(WIDTH-1){1'b0}}, 1'b1})
                         : acc_q[2*WIDTH-1:WIDTH];
        end
        dz_d    = 1'b0;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= {CW{1'b0}};
      acc_q     <= {(2*WIDTH){1'b0}};
      a_q       <= {WIDTH{1'b0}};
      b_q       <= {WIDTH{1'b0}};
      sign_q    <= 1'b0;
      dsign_q   <= 1'b0;
      dz_q      <= 1'b0;
      is_mult_q <= 1'b0;
      hi_q      <= {WIDTH{1'b0}};
      lo_q      <= {WIDTH{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sign_q    <= sign_d;
      dsign_q   <= dsign_d;
      dz_q      <= dz_d;
      is_mult_q <= is_mult_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      divzero_q <= divzero_d;
    end
  end

  assign hi      = hi_q;
  assign lo      = lo_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign divZero = divzero_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit: latency, handshake, sign handling,
// divide-by-zero, overflow, mid-operation reset and start priority.
module tb_mult_div_unit;

  logic        clk;
  logic        reset;
  logic        multOp;
  logic        divOp;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        divZero;

  int cmp_cnt = 0;
  int err_cnt = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .multOp (multOp),
    .divOp  (divOp),
    .srcA   (srcA),
    .srcB   (srcB),
    .hi     (hi),
    .lo     (lo),
    .busy   (busy),
    .done   (done),
    .divZero(divZero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one start, wait (bounded) for done and check the handshake timing.
  task automatic run_op(input string tag, input logic m, input logic d,
                        input logic [31:0] a, input logic [31:0] b, input int exp_lat,
                        output logic [31:0] h, output logic [31:0] l, output logic dz);
    logic [31:0] ph;
    logic [31:0] pl;
    int n;
    int bcnt;
    ph = hi;
    pl = lo;
    @(negedge clk);
    multOp = m; divOp = d; srcA = a; srcB = b;
    @(posedge clk);
    #1;
    multOp = 1'b0; divOp = 1'b0;
    bcnt = 0;
    for (n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (done) break;
      if (busy) bcnt++;
      if (n == 16) begin
        chk({tag, "_hi_hold"}, hi, ph);
        chk({tag, "_lo_hold"}, lo, pl);
      end
    end
    chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
    chk({tag, "_busy_cycles"}, 32'(bcnt), 32'(exp_lat - 1));
    chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    h  = hi;
    l  = lo;
    dz = divZero;
    @(negedge clk);
    chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    chk({tag, "_dz_pulse"}, {31'd0, divZero}, 32'd0);
  endtask

  initial begin
    logic [31:0] h;
    logic [31:0] l;
    logic        dz;
    int          dcnt;

    reset = 1'b0; multOp = 1'b0; divOp = 1'b0; srcA = 32'd0; srcB = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_flags", {29'd0, busy, done, divZero}, 32'd0);
    reset = 1'b1;

    // 7 * -3
    run_op("mul_7_m3", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 34, h, l, dz);
    chk("mul_7_m3_hi", h, 32'hFFFF_FFFF);
    chk("mul_7_m3_lo", l, 32'hFFFF_FFEB);
    chk("mul_7_m3_dz", {31'd0, dz}, 32'd0);

    // -7 / 2
    run_op("div_m7_2", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 34, h, l, dz);
    chk("div_m7_2_lo", l, 32'hFFFF_FFFD);
    chk("div_m7_2_hi", h, 32'hFFFF_FFFF);

    // 7 / -2
    run_op("div_7_m2", 1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE, 34, h, l, dz);
    chk("div_7_m2_lo", l, 32'hFFFF_FFFD);
    chk("div_7_m2_hi", h, 32'd1);

    // Preload hi/lo = 0x1234/0x5678, then 5 / 0 must leave them untouched
    run_op("preload", 1'b0, 1'b1, 32'h5678_1234, 32'h0001_0000, 34, h, l, dz);
    chk("preload_hi", h, 32'h0000_1234);
    chk("preload_lo", l, 32'h0000_5678);
    run_op("div_by_0", 1'b0, 1'b1, 32'd5, 32'd0, 2, h, l, dz);
    chk("div_by_0_dz", {31'd0, dz}, 32'd1);
    chk("div_by_0_hi", h, 32'h0000_1234);
    chk("div_by_0_lo", l, 32'h0000_5678);

    // Overflow quotient wraps
    run_op("div_ovf", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 34, h, l, dz);
    chk("div_ovf_lo", l, 32'h8000_0000);
    chk("div_ovf_hi", h, 32'd0);
    chk("div_ovf_dz", {31'd0, dz}, 32'd0);

    // Most-negative squared
    run_op("mul_min", 1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 34, h, l, dz);
    chk("mul_min_hi", h, 32'h4000_0000);
    chk("mul_min_lo", l, 32'd0);

    // Multiply, stray divOp (divide-by-zero if it were taken) at cycle 10, reset at cycle 20
    @(negedge clk);
    multOp = 1'b1; srcA = 32'd7; srcB = 32'hFFFF_FFFD;
    @(posedge clk);
    #1;
    multOp = 1'b0;
    repeat (9) @(negedge clk);
    divOp = 1'b1; srcB = 32'd0;
    @(negedge clk);
    divOp = 1'b0;
    chk("abort_busy_mid", {31'd0, busy}, 32'd1);
    repeat (9) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    chk("abort_flags", {29'd0, busy, done, divZero}, 32'd0);
    reset = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("abort_no_done", 32'(dcnt), 32'd0);

    run_op("mul_3_4", 1'b1, 1'b0, 32'd3, 32'd4, 34, h, l, dz);
    chk("mul_3_4_lo", l, 32'd12);
    chk("mul_3_4_hi", h, 32'd0);

    // Both requests: multiply wins
    run_op("both_6_3", 1'b1, 1'b1, 32'd6, 32'd3, 34, h, l, dz);
    chk("both_6_3_lo", l, 32'd18);
    chk("both_6_3_hi", h, 32'd0);
    chk("both_6_3_dz", {31'd0, dz}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
